garble_and_seq: RTL and testbench

//  Parametrised garbled-AND table generator (free-XOR, point-and-permute, 4->3 row reduction).

---
 rtl/garble_and_seq.sv | 202 ++++++++++++++++++++
 tb/tb_garble_and_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/garble_and_seq.sv
// garble_and_seq: garbled-AND table generator (free-XOR, point-and-permute, 4->3 row
// reduction) driving one shared external hash engine.
//
// Optional feature: define GARBLE_FREEXOR_EN to add in_op (0=AND, 1=XOR). An XOR gate
// issues no hash requests and returns Gc=Ga^Gb with zero ciphertexts.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          gate request handshake (ready only while idle)
//   in_R, in_Ga, in_Gb, in_gid free-XOR offset, zero labels of wires a/b, gate id
//   hash_req_*                 row hash request (keys kp/kq, tweak = gate id)
//   hash_rsp_valid/digest      in-order hash responses, top LABEL_W digest bits used
//   out_valid/out_ready        result handshake; data held until accepted
//   out_Gc, out_T01/T10/T11    output zero label and the three transmitted ciphertexts
//   err_spurious               sticky flag: hash response with nothing outstanding
module garble_and_seq #(
    parameter int unsigned LABEL_W = 80,
    parameter int unsigned GID_W   = 64,
    parameter int unsigned HASH_W  = 160
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
`ifdef GARBLE_FREEXOR_EN
    input  logic               in_op,
`endif
    input  logic [LABEL_W-1:0] in_R,
    input  logic [LABEL_W-1:0] in_Ga,
    input  logic [LABEL_W-1:0] in_Gb,
    input  logic [GID_W-1:0]   in_gid,
    output logic               hash_req_valid,
    input  logic               hash_req_ready,
    output logic [LABEL_W-1:0] hash_kp,
    output logic [LABEL_W-1:0] hash_kq,
    output logic [GID_W-1:0]   hash_tweak,
    input  logic               hash_rsp_valid,
    input  logic [HASH_W-1:0]  hash_rsp_digest,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] out_Gc,
    output logic [LABEL_W-1:0] out_T01,
    output logic [LABEL_W-1:0] out_T10,
    output logic [LABEL_W-1:0] out_T11,
    output logic               err_spurious
);

    typedef enum logic [1:0] {StIdle, StRun, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [LABEL_W-1:0] r_q, r_d, ga_q, ga_d, gb_q, gb_d;
    logic [GID_W-1:0]   gid_q, gid_d;
    logic               op_q, op_d;
    logic [2:0]         ic_q, ic_d, rc_q, rc_d;
    logic [LABEL_W-1:0] h_q [4];
    logic [LABEL_W-1:0] h_d [4];
    logic [LABEL_W-1:0] gc_q, gc_d, t01_q, t01_d, t10_q, t10_d, t11_q, t11_d;
    logic               err_q, err_d;

    logic               pa, pb, req_fire, rsp_take, in_op_w;
    logic               v00, v01, v10, v11;
    logic [LABEL_W-1:0] c0, c1;
    logic               unused_digest;

`ifdef GARBLE_FREEXOR_EN
    assign in_op_w = in_op;
`else
    assign in_op_w = 1'b0;
`endif

    // Only the top LABEL_W digest bits carry the row pad.
    assign unused_digest = ^hash_rsp_digest;

    assign pa = ga_q[0];
    assign pb = gb_q[0];

    // Row ij = ic: i = ic[1], j = ic[0]; keys select the label whose colour equals i / j.
    assign hash_req_valid = (state_q == StRun) && (ic_q != 3'd4);
    assign hash_kp        = ga_q ^ (r_q & {LABEL_W{ic_q[1] ^ pa}});
    assign hash_kq        = gb_q ^ (r_q & {LABEL_W{ic_q[0] ^ pb}});
    assign hash_tweak     = gid_q;

    assign req_fire = hash_req_valid & hash_req_ready;
    // A response is legal only while a request is outstanding (rc < ic).
    assign rsp_take = hash_rsp_valid && (state_q == StRun) && (rc_q < ic_q);

    // v_ij: colour row ij holds the wire pair (a=1, b=1).
    assign v00 = pa & pb;
    assign v01 = pa & ~pb;
    assign v10 = ~pa & pb;
    assign v11 = ~pa & ~pb;
    // Row 00 is made implicitly zero by choosing C0 so that H00 decodes to itself.
    assign c0  = v00 ? (h_q[0] ^ r_q) : h_q[0];
    assign c1  = c0 ^ r_q;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        ga_d    = ga_q;
        gb_d    = gb_q;
        gid_d   = gid_q;
        op_d    = op_q;
        ic_d    = ic_q;
        rc_d    = rc_q;
        h_d     = h_q;
        gc_d    = gc_q;
        t01_d   = t01_q;
        t10_d   = t10_q;
        t11_d   = t11_q;
        err_d   = err_q | (hash_rsp_valid & ~rsp_take);

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    r_d     = in_R;
                    ga_d    = in_Ga;
                    gb_d    = in_Gb;
                    gid_d   = in_gid;
                    op_d    = in_op_w;
                    ic_d    = 3'd0;
                    rc_d    = 3'd0;
                    state_d = in_op_w ? StCalc : StRun;
                end
            end
            StRun: begin
                if (req_fire) begin
                    ic_d = ic_q + 3'd1;
                end
                if (rsp_take) begin
                    h_d[rc_q[1:0]] = hash_rsp_digest[HASH_W-1 -: LABEL_W];
                    rc_d           = rc_q + 3'd1;
                end
                if (rc_q == 3'd4) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (op_q) begin
                    gc_d  = ga_q ^ gb_q;
                    t01_d = '0;
                    t10_d = '0;
                    t11_d = '0;
                end else begin
                    gc_d  = c0;
                    t01_d = h_q[1] ^ (v01 ? c1 : c0);
                    t10_d = h_q[2] ^ (v10 ? c1 : c0);
                    t11_d = h_q[3] ^ (v11 ? c1 : c0);
                end
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            r_q     <= '0;
            ga_q    <= '0;
            gb_q    <= '0;
            gid_q   <= '0;
            op_q    <= 1'b0;
            ic_q    <= '0;
            rc_q    <= '0;
            h_q     <= '{default: '0};
            gc_q    <= '0;
            t01_q   <= '0;
            t10_q   <= '0;
            t11_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            ga_q    <= ga_d;
            gb_q    <= gb_d;
            gid_q   <= gid_d;
            op_q    <= op_d;
            ic_q    <= ic_d;
            rc_q    <= rc_d;
            h_q     <= h_d;
            gc_q    <= gc_d;
            t01_q   <= t01_d;
            t10_q   <= t10_d;
            t11_q   <= t11_d;
            err_q   <= err_d;
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StDone);
    assign out_Gc       = gc_q;
    assign out_T01      = t01_q;
    assign out_T10      = t10_q;
    assign out_T11      = t11_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_garble_and_seq.sv
// Scoreboard bench for garble_and_seq: directed gates, a behavioural hash engine with
// configurable ready pattern and response latency, and a monitor that checks every
// emitted table by decoding all four wire-value combinations.
module tb_garble_and_seq;
    localparam int unsigned LW = 80;
    localparam int unsigned GW = 64;
    localparam int unsigned HW = 160;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
`ifdef GARBLE_FREEXOR_EN
    logic          in_op = 1'b0;
`endif
    logic [LW-1:0] in_R = '0, in_Ga = '0, in_Gb = '0;
    logic [GW-1:0] in_gid = '0;
    logic          hash_req_valid, hash_req_ready;
    logic [LW-1:0] hash_kp, hash_kq;
    logic [GW-1:0] hash_tweak;
    logic          hash_rsp_valid;
    logic [HW-1:0] hash_rsp_digest;
    logic          out_valid, out_ready = 1'b1;
    logic [LW-1:0] out_Gc, out_T01, out_T10, out_T11;
    logic          err_spurious;

    always #5 clk = ~clk;

    garble_and_seq #(.LABEL_W(LW), .GID_W(GW), .HASH_W(HW)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
`ifdef GARBLE_FREEXOR_EN
        .in_op          (in_op),
`endif
        .in_R           (in_R),
        .in_Ga          (in_Ga),
        .in_Gb          (in_Gb),
        .in_gid         (in_gid),
        .hash_req_valid (hash_req_valid),
        .hash_req_ready (hash_req_ready),
        .hash_kp        (hash_kp),
        .hash_kq        (hash_kq),
        .hash_tweak     (hash_tweak),
        .hash_rsp_valid (hash_rsp_valid),
        .hash_rsp_digest(hash_rsp_digest),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_Gc         (out_Gc),
        .out_T01        (out_T01),
        .out_T10        (out_T10),
        .out_T11        (out_T11),
        .err_spurious   (err_spurious)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string name, input logic [399:0] act, input logic [399:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // mode 0: H(kp,kq) = {kp^kq, kq}; mode 1: a non-linear mix for stronger tables.
    function automatic logic [HW-1:0] hfun(input logic [LW-1:0] kp, input logic [LW-1:0] kq,
                                           input int mode);
        logic [LW-1:0] top;
        if (mode == 0) top = kp ^ kq;
        else top = kp ^ {kq[LW-2:0], kq[LW-1]} ^ (kp & kq) ^ 80'h5A5A_0F0F_3C3C_9696_A5A5;
        return {top, kq};
    endfunction

    typedef struct {
        logic [LW-1:0] r, ga, gb;
        logic          is_xor, has_exp;
        logic [LW-1:0] gc, t01, t10, t11;
        int            hm;
    } sb_t;
    typedef struct {
        int            due;
        logic [HW-1:0] dig;
    } rsp_t;

    sb_t            sb[$];
    rsp_t           rsp_q[$];
    logic [223:0]   key_q[$];
    bit             rdy_pat[$];
    int             cyc = 0;
    int             lat = 1;
    int             hmode = 0;
    int             n_acc = 0;
    bit             spur_inj = 1'b0;

    // Hash engine: drives ready/response just after each rising edge.
    initial begin
        logic rst_seen;
        rsp_t e;
        hash_req_ready  = 1'b1;
        hash_rsp_valid  = 1'b0;
        hash_rsp_digest = '0;
        forever begin
            @(posedge clk);
            rst_seen = reset;
            #1;
            cyc++;
            if (rst_seen) begin
                rsp_q.delete();
                hash_rsp_valid = 1'b0;
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                e = rsp_q.pop_front();
                hash_rsp_valid  = 1'b1;
                hash_rsp_digest = e.dig;
            end else begin
                hash_rsp_valid = spur_inj;
            end
            hash_req_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
        end
    end

    // Request acceptance, key order and stall-hold checks, sampled mid-cycle.
    bit           stall_prev = 1'b0;
    logic [224:0] prev_req;
    always @(negedge clk) begin
        logic [223:0] k;
        if (!reset && stall_prev)
            check_eq("req_hold", {hash_req_valid, hash_kp, hash_kq, hash_tweak}, prev_req);
        if (!reset && hash_req_valid && hash_req_ready) begin
            rsp_q.push_back('{due: cyc + lat, dig: hfun(hash_kp, hash_kq, hmode)});
            n_acc++;
            if (key_q.size() > 0) begin
                k = key_q.pop_front();
                check_eq("req_keys", {hash_kp, hash_kq, hash_tweak}, k);
            end
        end
        stall_prev = !reset && hash_req_valid && !hash_req_ready;
        prev_req   = {1'b1, hash_kp, hash_kq, hash_tweak};
    end

    // Output monitor: pops the scoreboard on every result handshake.
    always @(negedge clk) begin
        sb_t           e;
        logic [LW-1:0] a_l, b_l, t, h;
        logic [HW-1:0] d;
        if (!reset && out_valid && out_ready) begin
            check_eq("out_has_request", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.is_xor) begin
                    check_eq("xor_gc", out_Gc, e.ga ^ e.gb);
                    check_eq("xor_t", {out_T01, out_T10, out_T11}, '0);
                end else begin
                    for (int a = 0; a < 2; a++) begin
                        for (int b = 0; b < 2; b++) begin
                            a_l = e.ga ^ ((a == 1) ? e.r : '0);
                            b_l = e.gb ^ ((b == 1) ? e.r : '0);
                            d = hfun(a_l, b_l, e.hm);
                            h = d[HW-1 -: LW];
                            case ({a_l[0], b_l[0]})
                                2'b01:   t = out_T01;
                                2'b10:   t = out_T10;
                                2'b11:   t = out_T11;
                                default: t = '0;
                            endcase
                            check_eq($sformatf("decode_a%0d_b%0d", a, b), h ^ t,
                                     out_Gc ^ ((a == 1 && b == 1) ? e.r : '0));
                        end
                    end
                    if (e.has_exp) begin
                        check_eq("exp_gc", out_Gc, e.gc);
                        check_eq("exp_t01", out_T01, e.t01);
                        check_eq("exp_t10", out_T10, e.t10);
                        check_eq("exp_t11", out_T11, e.t11);
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [LW-1:0] r, input logic [LW-1:0] ga, input logic [LW-1:0] gb,
                         input logic [GW-1:0] gid, input logic op, input int hm,
                         input logic has_exp, input logic [LW-1:0] xgc, input logic [LW-1:0] x01,
                         input logic [LW-1:0] x10, input logic [LW-1:0] x11);
        sb_t e;
        int  k;
        in_R = r; in_Ga = ga; in_Gb = gb; in_gid = gid;
`ifdef GARBLE_FREEXOR_EN
        in_op = op;
`endif
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
        end else begin
            e = '{r: r, ga: ga, gb: gb, is_xor: op, has_exp: has_exp,
                  gc: xgc, t01: x01, t10: x10, t11: x11, hm: hm};
            sb.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    localparam logic [LW-1:0] RV = 80'hDEAD_BEEF_0123_4567_89AB;
    localparam logic [LW-1:0] G1 = 80'h1357_9BDF_2468_ACE0_FFFE;
    localparam logic [LW-1:0] G2 = 80'h8642_0ECA_7531_FDB9_0001;
    localparam logic [LW-1:0] G3 = 80'hAAAA_5555_CCCC_3333_0F0F;
    localparam logic [LW-1:0] G4 = 80'h1234_5678_9ABC_DEF0_1110;

    initial begin
        int            n;
        logic [319:0]  snap;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_req_valid", hash_req_valid, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", {out_Gc, out_T01, out_T10, out_T11}, '0);
        check_eq("rst_err", err_spurious, 0);

        // 1: pa=pb=0, linear hash; Gc=H00=1E, all T=01, latency 7
        hmode = 0; lat = 1;
        key_q.push_back({80'h0A, 80'h14, 64'h11});
        key_q.push_back({80'h0A, 80'h15, 64'h11});
        key_q.push_back({80'h0B, 80'h14, 64'h11});
        key_q.push_back({80'h0B, 80'h15, 64'h11});
        issue(80'h01, 80'h0A, 80'h14, 64'h11, 1'b0, 0, 1'b1, 80'h1E, 80'h01, 80'h01, 80'h01);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency_and", n, 7);
        drain();
        check_eq("keys_consumed", key_q.size(), 0);

        // 2: pa=pb=1; row 00 keys (Ga^R, Gb^R), Gc=H00^R=1F
        key_q.push_back({80'h0A, 80'h14, 64'h22});
        issue(80'h01, 80'h0B, 80'h15, 64'h22, 1'b0, 0, 1'b1, 80'h1F, 80'h00, 80'h00, 80'h01);
        drain();

        // 3: stalled requests, 3-cycle responses, same result as test 1
        lat = 3;
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        issue(80'h01, 80'h0A, 80'h14, 64'h33, 1'b0, 0, 1'b1, 80'h1E, 80'h01, 80'h01, 80'h01);
        drain();
        lat = 1;

        // 4: downstream back-pressure for 5 cycles
        hmode = 1;
        out_ready = 1'b0;
        issue(RV, G1, G2, 64'h44, 1'b0, 1, 1'b0, '0, '0, '0, '0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("bp_out_valid", out_valid, 1);
        snap = {out_Gc, out_T01, out_T10, out_T11};
        in_R = RV; in_Ga = G3; in_Gb = G4; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_eq("bp_hold_valid", out_valid, 1);
            check_eq("bp_hold_data", {out_Gc, out_T01, out_T10, out_T11}, snap);
            check_eq("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        issue(RV, G3, G4, 64'h45, 1'b0, 1, 1'b0, '0, '0, '0, '0);
        drain();

        // 5: reset in RUN after two accepted requests
        n = n_acc;
        issue(RV, G3, G2, 64'h55, 1'b0, 1, 1'b0, '0, '0, '0, '0);
        for (int c = 0; c < 20 && n_acc < n + 2; c++) begin
            @(posedge clk); #1;
        end
        check_eq("two_reqs", n_acc - n, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        key_q.delete();
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_req_valid", hash_req_valid, 0);
        issue(RV, G3, G2, 64'h56, 1'b0, 1, 1'b0, '0, '0, '0, '0);
        drain();
        check_eq("err_clean", err_spurious, 0);

        // 6: spurious response while idle sets a sticky error
        spur_inj = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        spur_inj = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check_eq("err_set", err_spurious, 1);
        issue(RV, G2, G2 ^ 80'h0F00, 64'h66, 1'b0, 1, 1'b0, '0, '0, '0, '0);
        drain();
        check_eq("err_sticky", err_spurious, 1);

`ifdef GARBLE_FREEXOR_EN
        // XOR gate: no hash traffic, result the cycle after accept
        n = n_acc;
        issue(RV, G1, G4, 64'h77, 1'b1, 1, 1'b0, '0, '0, '0, '0);
        check_eq("xor_latency", out_valid, 1);
        drain();
        check_eq("xor_no_hash", n_acc - n, 0);
        in_op = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
